// File: rtl/mwc_pkg.sv
// Shared types for the memory-write checker: FSM state encoding and verdict error codes.
package mwc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ADDR    = 3'd1,
    ERR_DATA    = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_EMPTY   = 3'd4
  } err_t;

endpackage

// File: rtl/mem_write_checker_if.sv
// Bundle of the programming, monitored-write and verdict signals of mem_write_checker.
interface mem_write_checker_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
);
  localparam int MIW = $clog2(DEPTH) + 1;

  logic             prog_valid;
  logic [WIDTH-1:0] prog_addr;
  logic [WIDTH-1:0] prog_data;
  logic             prog_ready;
  logic             start;
  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;
  logic             done;
  logic             pass;
  logic             fail;
  logic [2:0]       err_code;
  logic [MIW-1:0]   match_idx;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] write_count;

  modport master (
    output prog_valid, prog_addr, prog_data, start, memwrite, dataadr, writedata,
    input  prog_ready, done, pass, fail, err_code, match_idx, cycle_count, write_count
  );

  modport slave (
    input  prog_valid, prog_addr, prog_data, start, memwrite, dataadr, writedata,
    output prog_ready, done, pass, fail, err_code, match_idx, cycle_count, write_count
  );
endinterface

// File: rtl/mwc_exp_table.sv
// Ordered table of expected (address, data) writes: appended at the fill pointer, read by match index.
module mwc_exp_table #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int MIW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [MIW-1:0]   i_rd_idx,
  output logic [MIW-1:0]   o_fill,
  output logic [WIDTH-1:0] o_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_addr [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [MIW-1:0]   r_fill;
  logic [IDX_W-1:0] w_wr_ptr;
  logic [IDX_W-1:0] w_rd_ptr;
  logic             w_rd_ok;

  assign w_wr_ptr = r_fill[IDX_W-1:0];
  assign w_rd_ptr = i_rd_idx[IDX_W-1:0];
  // Index reaches DEPTH only once the run has already passed; return zeros rather than alias.
  assign w_rd_ok  = (i_rd_idx < MIW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill <= '0;
    end else if (i_wr_en) begin
      r_fill <= r_fill + MIW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_addr[w_wr_ptr] <= i_wr_addr;
      r_data[w_wr_ptr] <= i_wr_data;
    end
  end

  assign o_fill    = r_fill;
  assign o_rd_addr = w_rd_ok ? r_addr[w_rd_ptr] : '0;
  assign o_rd_data = w_rd_ok ? r_data[w_rd_ptr] : '0;
endmodule

// File: rtl/mem_write_checker.sv
// Checks processor data-memory writes against a programmed ordered table; sticky pass/fail verdict.
// MWC_IGNORE_EN defined: writes to IGN_ADDR are tolerated instead of failing.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 1000,
  parameter int IGN_ADDR = 80,
  parameter int CNT_W    = 32
) (
  input logic               clk,
  input logic               reset,
  mem_write_checker_if.slave bus
);
  localparam int MIW = $clog2(DEPTH) + 1;

  state_t           r_state, w_state_nxt;
  logic             r_prog_ready, r_done, r_pass, r_fail;
  logic [2:0]       r_err, w_err_nxt;
  logic [MIW-1:0]   r_match_idx, w_match_nxt, w_match_inc;
  logic [CNT_W-1:0] r_cycle, w_cycle_nxt;
  logic [CNT_W-1:0] r_wcount, w_wcount_nxt;
  logic [MIW-1:0]   w_fill, w_fill_after;
  logic [WIDTH-1:0] w_exp_addr, w_exp_data;
  logic             w_accept, w_addr_hit, w_data_hit, w_ign_en, w_ign_hit;

  mwc_exp_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_table (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_accept),
    .i_wr_addr (bus.prog_addr),
    .i_wr_data (bus.prog_data),
    .i_rd_idx  (r_match_idx),
    .o_fill    (w_fill),
    .o_rd_addr (w_exp_addr),
    .o_rd_data (w_exp_data)
  );

`ifdef MWC_IGNORE_EN
  assign w_ign_en = 1'b1;
`else
  assign w_ign_en = 1'b0;
`endif

  // prog_ready is only ever high in IDLE with room left, so it alone qualifies the accept.
  assign w_accept     = bus.prog_valid & r_prog_ready;
  assign w_fill_after = w_fill + MIW'(w_accept);
  assign w_addr_hit   = (bus.dataadr == w_exp_addr);
  assign w_data_hit   = (bus.writedata == w_exp_data);
  assign w_ign_hit    = w_ign_en && (bus.dataadr == WIDTH'(IGN_ADDR));
  assign w_match_inc  = r_match_idx + MIW'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_err_nxt    = r_err;
    w_match_nxt  = r_match_idx;
    w_cycle_nxt  = r_cycle;
    w_wcount_nxt = r_wcount;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_fill_after == '0) begin
            w_state_nxt = S_FAIL;
            w_err_nxt   = ERR_EMPTY;
          end else begin
            w_state_nxt = S_RUN;
            w_cycle_nxt = CNT_W'(1);
          end
        end
      end
      S_RUN: begin
        if (bus.memwrite) begin
          if (r_wcount != '1) w_wcount_nxt = r_wcount + CNT_W'(1);
          if (w_addr_hit && w_data_hit) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == w_fill) w_state_nxt = S_PASS;
          end else if (!w_ign_hit) begin
            w_state_nxt = S_FAIL;
            w_err_nxt   = w_addr_hit ? ERR_DATA : ERR_ADDR;
          end
        end
        // A write verdict on the last allowed cycle takes precedence over the timeout.
        if (w_state_nxt == S_RUN) begin
          if ((TIMEOUT != 0) && (r_cycle == CNT_W'(TIMEOUT))) begin
            w_state_nxt = S_FAIL;
            w_err_nxt   = ERR_TIMEOUT;
          end else if (r_cycle != '1) begin
            w_cycle_nxt = r_cycle + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_prog_ready <= 1'b1;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_err        <= ERR_NONE;
      r_match_idx  <= '0;
      r_cycle      <= '0;
      r_wcount     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prog_ready <= (w_state_nxt == S_IDLE) && (w_fill_after < MIW'(DEPTH));
      r_done       <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL);
      r_pass       <= (w_state_nxt == S_PASS);
      r_fail       <= (w_state_nxt == S_FAIL);
      r_err        <= w_err_nxt;
      r_match_idx  <= w_match_nxt;
      r_cycle      <= w_cycle_nxt;
      r_wcount     <= w_wcount_nxt;
    end
  end

  assign bus.prog_ready  = r_prog_ready;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.fail        = r_fail;
  assign bus.err_code    = r_err;
  assign bus.match_idx   = r_match_idx;
  assign bus.cycle_count = r_cycle;
  assign bus.write_count = r_wcount;
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed and randomized bench for mem_write_checker against a queue-based model of the checking rules.
module tb_mem_write_checker;
  localparam int WIDTH = 32, DEPTH = 4, TIMEOUT = 20, IGN = 80, CNT_W = 32;

`ifdef MWC_IGNORE_EN
  localparam bit IGN_EN = 1'b1;
`else
  localparam bit IGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_write_checker_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  mem_write_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IGN_ADDR(IGN), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected writes kept in programming order.
  logic [31:0] m_addr[$];
  logic [31:0] m_data[$];
  int m_idx, m_cyc, m_wr, m_err;
  bit m_run, m_pass, m_fail;
  logic [31:0] ent_a[4];
  logic [31:0] ent_d[4];

  task automatic model_reset();
    m_addr.delete(); m_data.delete();
    m_idx = 0; m_cyc = 0; m_wr = 0; m_err = 0;
    m_run = 0; m_pass = 0; m_fail = 0;
  endtask

  task automatic model_edge();
    bit decided;
    decided = 0;
    if (m_pass || m_fail) return;
    if (!m_run) begin
      if (bus.prog_valid && m_addr.size() < DEPTH) begin
        m_addr.push_back(bus.prog_addr);
        m_data.push_back(bus.prog_data);
      end
      if (bus.start) begin
        if (m_addr.size() == 0) begin m_fail = 1; m_err = 4; end
        else begin m_run = 1; m_cyc = 1; end
      end
    end else begin
      if (bus.memwrite) begin
        m_wr++;
        if (bus.dataadr == m_addr[m_idx] && bus.writedata == m_data[m_idx]) begin
          m_idx++;
          if (m_idx == m_addr.size()) begin m_pass = 1; decided = 1; end
        end else if (!(IGN_EN && bus.dataadr == IGN)) begin
          m_fail = 1; decided = 1;
          m_err = (bus.dataadr == m_addr[m_idx]) ? 2 : 1;
        end
      end
      if (!decided) begin
        if (m_cyc == TIMEOUT) begin m_fail = 1; m_err = 3; end
        else m_cyc++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("done", bus.done, 64'(m_pass | m_fail));
    chk("pass", bus.pass, 64'(m_pass));
    chk("fail", bus.fail, 64'(m_fail));
    chk("err_code", bus.err_code, 64'(m_err));
    chk("match_idx", bus.match_idx, 64'(m_idx));
    chk("cycle_count", bus.cycle_count, 64'(m_cyc));
    chk("write_count", bus.write_count, 64'(m_wr));
    chk("prog_ready", bus.prog_ready,
        64'(!m_run && !m_pass && !m_fail && m_addr.size() < DEPTH));
  endtask

  task automatic clear_in();
    bus.prog_valid = 0; bus.prog_addr = '0; bus.prog_data = '0; bus.start = 0;
    bus.memwrite = 0; bus.dataadr = '0; bus.writedata = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    chk_all();
    clear_in();
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    @(posedge clk); #1;
    model_reset();
    chk_all();
    reset = 0;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    bus.prog_valid = 1; bus.prog_addr = a; bus.prog_data = d;
    tick();
  endtask

  task automatic go();
    bus.start = 1;
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite = 1; bus.dataadr = a; bus.writedata = d;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic make_entries();
    logic [31:0] base;
    base = 32'h1000 + ($urandom_range(0, 255) << 8);
    for (int i = 0; i < 4; i++) begin
      ent_a[i] = base + 32'(i * 16);
      ent_d[i] = $urandom;
    end
  endtask

  initial begin
    clear_in();
    model_reset();
    do_reset();
    chk("reset_prog_ready", bus.prog_ready, 1);
    chk("reset_done", bus.done, 0);

    // Ignored scratch write followed by the expected write.
    do_reset();
    prog(84, 7); go(); wr(80, $urandom); wr(84, 7);
    chk("t1_pass", bus.pass, IGN_EN ? 1 : 0);
    chk("t1_wc", bus.write_count, IGN_EN ? 2 : 1);
    chk("t1_err", bus.err_code, IGN_EN ? 0 : 1);

    // Data mismatch at the expected address.
    do_reset();
    prog(84, 7); go(); wr(84, 6);
    chk("t2_fail", bus.fail, 1);
    chk("t2_err", bus.err_code, 2);
    chk("t2_idx", bus.match_idx, 0);
    idle(2); wr(84, 7);
    chk("t2_sticky", bus.pass, 0);

    // Wrong address, then a write to the scratch address.
    do_reset();
    prog(84, 7); go(); wr(88, 7);
    chk("t3_err", bus.err_code, 1);
    do_reset();
    prog(84, 7); go(); wr(80, 0);
    chk("t3_ign_fail", bus.fail, IGN_EN ? 0 : 1);
    chk("t3_ign_err", bus.err_code, IGN_EN ? 0 : 1);

    // Timeout with no writes.
    do_reset();
    prog(84, 7); go(); idle(TIMEOUT + 5);
    chk("t4_fail", bus.fail, 1);
    chk("t4_err", bus.err_code, 3);
    chk("t4_cyc", bus.cycle_count, TIMEOUT);

    // Full table, extra entry ignored, in-order matches with random gaps.
    do_reset();
    make_entries();
    for (int i = 0; i < 4; i++) prog(ent_a[i], ent_d[i]);
    chk("t5_full", bus.prog_ready, 0);
    prog(32'h9999, 32'h1); go();
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 2));
      wr(ent_a[i], ent_d[i]);
    end
    chk("t5_pass", bus.pass, 1);
    chk("t5_idx", bus.match_idx, 4);

    // Out-of-order write.
    do_reset();
    make_entries();
    for (int i = 0; i < 4; i++) prog(ent_a[i], ent_d[i]);
    go(); wr(ent_a[1], ent_d[1]);
    chk("t6_err", bus.err_code, 1);

    // Empty table.
    do_reset();
    go();
    chk("t7_err", bus.err_code, 4);

    // Reset mid-run, then reprogram.
    do_reset();
    prog(84, 7); go(); idle(3);
    do_reset();
    chk("t8_ready", bus.prog_ready, 1);
    chk("t8_cyc", bus.cycle_count, 0);
    prog(96, 5); go(); wr(96, 5);
    chk("t8_pass", bus.pass, 1);

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      int n;
      do_reset();
      make_entries();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) tick();
        bus.prog_valid = 1; bus.prog_addr = ent_a[i]; bus.prog_data = ent_d[i];
        if (i == n - 1 && $urandom_range(0, 1) == 1) bus.start = 1;
        tick();
      end
      if (!m_run && !m_fail) go();
      for (int c = 0; c < 30; c++) begin
        int k;
        k = $urandom_range(0, 19);
        if (m_run && !m_pass && !m_fail) begin
          if (k < 9) begin
            bus.memwrite = 1; bus.dataadr = m_addr[m_idx]; bus.writedata = m_data[m_idx];
          end else if (k < 11) begin
            bus.memwrite = 1; bus.dataadr = IGN; bus.writedata = $urandom;
          end else if (k == 11) begin
            bus.memwrite = 1; bus.dataadr = m_addr[m_idx]; bus.writedata = m_data[m_idx] ^ 32'h1;
          end else if (k == 12) begin
            bus.memwrite = 1; bus.dataadr = 32'h44; bus.writedata = $urandom;
          end
        end else begin
          bus.memwrite = k[0]; bus.start = k[1]; bus.prog_valid = k[2];
          bus.dataadr = ent_a[0]; bus.writedata = ent_d[0];
        end
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised memory-write checker that watches the processor's data-memory write port and issues a pass/fail verdict against a programmed sequence of expected writes. It sits beside `top` in simulation and FPGA bring-up builds. It generalises the single-address, single-value check into an ordered table of DEPTH expected writes, a tolerated scratch address, a cycle timeout, and error codes.

## Interface
Parameters:
- WIDTH, 32, address/data width of the monitored bus
- DEPTH, 4, number of expected-write table entries (≥1)
- TIMEOUT, 1000, RUN cycles before timeout failure; 0 disables the timeout
- IGN_ADDR, 80, address whose writes are tolerated and not checked
- CNT_W, 32, width of the cycle and write counters

Ports:
- clk, in, 1, single clock; all state updates on rising edge
- reset, in, 1, synchronous, active-high
- prog_valid, in, 1, expected-entry write request
- prog_addr, in, WIDTH, expected address
- prog_data, in, WIDTH, expected data
- prog_ready, out, 1, table accepts an entry this cycle
- start, in, 1, begin checking (sampled in IDLE only)
- memwrite, in, 1, processor write strobe
- dataadr, in, WIDTH, processor write address
- writedata, in, WIDTH, processor write data
- done, out, 1, verdict reached
- pass, out, 1, all expected writes matched
- fail, out, 1, check failed
- err_code, out, 3, 0 none, 1 unexpected address, 2 data mismatch, 3 timeout, 4 empty table
- match_idx, out, $clog2(DEPTH)+1, number of entries matched so far
- cycle_count, out, CNT_W, RUN cycles elapsed
- write_count, out, CNT_W, memwrite cycles seen in RUN

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE; all outputs 0 except prog_ready=1; fill pointer 0.
- IDLE: prog_ready = (fill < DEPTH). An entry is stored at the fill pointer when prog_valid && prog_ready, then fill increments. If the table is full, prog_ready=0 and prog_valid is ignored.
- IDLE + start: if fill==0 (after any same-cycle programming) → FAIL, err 4. Otherwise → RUN; an entry accepted in the same cycle is part of the run.
- RUN, each cycle: cycle_count++. When memwrite=1, write_count++ and the write is evaluated in priority order against entry e = table[match_idx]:
  - dataadr==e.addr && writedata==e.data: match_idx++. If this was the last entry (match_idx reaches fill) → PASS.
  - dataadr==IGN_ADDR: ignored.
  - dataadr==e.addr: FAIL, err 2.
  - otherwise: FAIL, err 1.
- Timeout: TIMEOUT≠0 and cycle_count reaches TIMEOUT with no verdict → FAIL, err 3. If the final match and the timeout fall on the same cycle, PASS wins.
- Each memwrite-high cycle counts as one write. A multi-cycle strobe of the same write is checked again.
- PASS/FAIL are terminal and sticky. start, prog_valid and memwrite are ignored. Counters freeze. Only reset leaves them.
- done = pass | fail. pass and fail are never both 1.
- Counters saturate at all-ones.

## Timing
- All outputs are registered. The verdict is visible in the cycle after the rising edge that sampled the deciding write.
- IDLE→RUN takes 1 cycle. cycle_count=1 in the first RUN cycle after the transition edge.
- reset asserted in any state → IDLE on that edge. The table is cleared (fill=0) and counters and err_code are zeroed.

## Configuration
- MWC_IGNORE_EN defined: the IGN_ADDR tolerance rule is active as described above.
- MWC_IGNORE_EN undefined: the IGN_ADDR rule is removed. Any non-matching write fails with err 1 or 2, and IGN_ADDR is unused.

## Structure
- Package mwc_pkg holds the state encoding (IDLE/RUN/PASS/FAIL) and the err_code constants (ERR_NONE, ERR_ADDR, ERR_DATA, ERR_TIMEOUT, ERR_EMPTY).
- Sub-module mwc_exp_table: a DEPTH×(2·WIDTH) register array with fill pointer, prog handshake, and read port indexed by match_idx.
- The FSM, counters and compare logic live in mem_write_checker.

## Test plan
- Program {84,7}, start, then writes 80/x and 84/7 → pass=1 one cycle after the 84 write, write_count=2, err 0.
- Program {84,7}, then write 84/6 → fail=1, err 2, match_idx=0.
- Program {84,7}, then write 88/7 → fail=1, err 1. Rerun the same case without MWC_IGNORE_EN and write 80/0 → fail, err 1.
- TIMEOUT=20, one entry programmed, no writes → fail=1, err 3, cycle_count=20.
- DEPTH=4: program 4 entries → prog_ready=0, and a 5th prog_valid is ignored. Matching the four writes in order → pass, match_idx=4. Out-of-order writes → err 1.
- Start with an empty table → fail, err 4. Assert reset mid-RUN → all outputs 0, prog_ready=1, and reprogramming works.
